// File: rtl/hilo_sched.sv
// hilo_sched: E-stage owner of the HI/LO pair. Launches the external
// fixed-latency multiplier or handshaked divider, stalls E while an op is in
// flight, commits results, and serves MFHI/MFLO/MTHI/MTLO.
//
// state | meaning
// IDLE  | no op in flight; MT*/MF* serviced, MULT*/DIV* launched from here
// MUL   | waiting for the multiplier; cnt counts down to the result cycle
// DIV   | waiting for div_done from the divider
// DONE  | result committed; stall released so the op leaves E, no relaunch
module hilo_sched #(
  parameter int MUL_LAT = 2
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        op_valid_e,
  input  logic [4:0]  alucontrol_e,
  input  logic [31:0] src_a_e,
  input  logic        flush,
  output logic        stall_e,
  output logic [31:0] hilo_rdata,
  output logic        mul_start,
  output logic        mul_signed,
  input  logic [63:0] mul_result,
  output logic        div_start,
  output logic        div_signed,
  output logic        div_cancel,
  input  logic        div_done,
  input  logic [63:0] div_result,
  output logic [31:0] hi_o,
  output logic [31:0] lo_o
);

  // ALU op encodings shared with the E-stage decoder
  localparam logic [4:0] ALU_MULT  = 5'd16;
  localparam logic [4:0] ALU_MULTU = 5'd17;
  localparam logic [4:0] ALU_DIV   = 5'd18;
  localparam logic [4:0] ALU_DIVU  = 5'd19;
  localparam logic [4:0] ALU_MTHI  = 5'd20;
  localparam logic [4:0] ALU_MTLO  = 5'd21;
  localparam logic [4:0] ALU_MFHI  = 5'd22;
  localparam logic [4:0] ALU_MFLO  = 5'd23;

  localparam int CW = (MUL_LAT > 1) ? $clog2(MUL_LAT) : 1;
  localparam logic [CW-1:0] CNT_INIT = CW'(MUL_LAT - 1);

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q;
  logic [31:0]   hi_q, lo_q;
  logic          mul_sgn_q, div_sgn_q;

  logic launch, is_mul, is_div, commit_mul, commit_div;

  // Op decode and qualified launch/commit strobes
  always_comb begin
    is_mul     = (alucontrol_e == ALU_MULT) || (alucontrol_e == ALU_MULTU);
    is_div     = (alucontrol_e == ALU_DIV)  || (alucontrol_e == ALU_DIVU);
    launch     = (state_q == S_IDLE) && op_valid_e && !flush;
    // flush wins over completion: a flushed result is dropped
    commit_mul = (state_q == S_MUL) && (cnt_q == '0) && !flush;
    commit_div = (state_q == S_DIV) && div_done && !flush;
  end

  // State register plus counter, signed flags and HI/LO
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
      mul_sgn_q <= 1'b0;
      div_sgn_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (launch && is_mul) begin
        cnt_q     <= CNT_INIT;
        mul_sgn_q <= (alucontrol_e == ALU_MULT);
      end else if ((state_q == S_MUL) && (cnt_q != '0)) begin
        cnt_q <= cnt_q - CW'(1);
      end
      if (launch && is_div) div_sgn_q <= (alucontrol_e == ALU_DIV);
      if (launch && (alucontrol_e == ALU_MTHI)) hi_q <= src_a_e;
      if (launch && (alucontrol_e == ALU_MTLO)) lo_q <= src_a_e;
      if (commit_mul) begin
        hi_q <= mul_result[63:32];
        lo_q <= mul_result[31:0];
      end
      if (commit_div) begin
        hi_q <= div_result[63:32];
        lo_q <= div_result[31:0];
      end
    end
  end

  // Next-state logic; flush returns to IDLE from anywhere
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (launch && is_mul)      state_d = S_MUL;
        else if (launch && is_div) state_d = S_DIV;
      end
      S_MUL:  if (cnt_q == '0) state_d = S_DONE;
      S_DIV:  if (div_done)    state_d = S_DONE;
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    if (flush) state_d = S_IDLE;
  end

  // Outputs; everything held at 0 while resetn is low
  always_comb begin
    stall_e    = 1'b0;
    mul_start  = 1'b0;
    mul_signed = 1'b0;
    div_start  = 1'b0;
    div_signed = 1'b0;
    div_cancel = 1'b0;
    hilo_rdata = '0;
    hi_o       = '0;
    lo_o       = '0;
    if (resetn) begin
      case (state_q)
        S_IDLE: begin
          stall_e    = launch && (is_mul || is_div);
          mul_start  = launch && is_mul;
          mul_signed = launch && (alucontrol_e == ALU_MULT);
          div_start  = launch && is_div;
          div_signed = launch && (alucontrol_e == ALU_DIV);
        end
        S_MUL: begin
          stall_e    = 1'b1;
          mul_signed = mul_sgn_q;
        end
        S_DIV: begin
          stall_e    = 1'b1;
          div_signed = div_sgn_q;
          div_cancel = flush;
        end
        default: ;
      endcase
      if (alucontrol_e == ALU_MFHI)      hilo_rdata = hi_q;
      else if (alucontrol_e == ALU_MFLO) hilo_rdata = lo_q;
      hi_o = hi_q;
      lo_o = lo_q;
    end
  end

endmodule
